// File: rtl/spike_pkg.sv
// Shared definitions for spike-train receivers.
//   - default widths for the spike rate/interval decoders
//   - ISI tracking state encoding
//   - sat_inc: increment that clamps at the all-ones value of a given width
package spike_pkg;

    localparam int unsigned DEF_WINDOW_LOG2 = 8;
    localparam int unsigned DEF_COUNT_W     = 8;
    localparam int unsigned DEF_ISI_W       = 8;

    typedef enum logic [0:0] {
        ISI_IDLE  = 1'b0,
        ISI_ARMED = 1'b1
    } isi_state_e;

    // Returns val+1, clamped to 2**width-1. Callers cast the result back to
    // their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge spike event detector.
//   clk, reset   : clock, synchronous active-high reset
//   enable       : gates event generation only
//   spike_in     : spike level, synchronous to clk
//   spike_event  : high for one cycle on an enabled rising edge of spike_in
module spike_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic spike_in,
    output logic spike_event
);

    logic prev_spike_q;
    logic prev_spike_d;

    // Tracks spike_in even while disabled, so a level that is already high
    // when enable rises does not produce an event.
    always_comb prev_spike_d = spike_in;

    always_ff @(posedge clk) begin
        if (reset) prev_spike_q <= 1'b0;
        else       prev_spike_q <= prev_spike_d;
    end

    assign spike_event = enable & spike_in & ~prev_spike_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: rate code (spikes per window) and temporal code
// (interval between consecutive spikes).
//   clk, reset  : clock, synchronous active-high reset
//   enable      : low freezes every counter and the ISI state
//   spike_in    : spike level from a neuron
//   rate_out    : spike count of the last completed window
//   rate_valid  : one-cycle pulse when rate_out updates
//   rate_sat    : last completed window saturated the count
//   isi_out     : enabled cycles between the last two spike events
//   isi_valid   : one-cycle pulse when isi_out updates
//   isi_sat     : isi_out is at its saturated value
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int unsigned COUNT_W     = DEF_COUNT_W,
    parameter int unsigned ISI_W       = DEF_ISI_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               spike_in,
    output logic [COUNT_W-1:0] rate_out,
    output logic               rate_valid,
    output logic               rate_sat,
    output logic [ISI_W-1:0]   isi_out,
    output logic               isi_valid,
    output logic               isi_sat
);

    logic spike_event;

    spike_edge_detect u_edge (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .spike_in    (spike_in),
        .spike_event (spike_event)
    );

    // Rate path state
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [COUNT_W-1:0]     spk_q, spk_d;
    logic                   sat_acc_q, sat_acc_d;
    logic [COUNT_W-1:0]     rate_out_q, rate_out_d;
    logic                   rate_valid_q, rate_valid_d;
    logic                   rate_sat_q, rate_sat_d;

    // ISI path state
    isi_state_e             isi_state_q, isi_state_d;
    logic [ISI_W-1:0]       isi_cnt_q, isi_cnt_d;
    logic [ISI_W-1:0]       isi_out_q, isi_out_d;
    logic                   isi_valid_q, isi_valid_d;
    logic                   isi_sat_q, isi_sat_d;

    logic                   win_end;
    logic [COUNT_W-1:0]     spk_next;
    logic                   spk_ovf;
    logic [ISI_W-1:0]       isi_inc;

    always_comb begin
        win_end  = enable & (win_q == '1);
        spk_next = spike_event ? COUNT_W'(sat_inc(32'(spk_q), COUNT_W)) : spk_q;
        spk_ovf  = spike_event & (spk_q == '1);

        win_d        = enable ? (win_q + WINDOW_LOG2'(1)) : win_q;
        spk_d        = spk_next;
        sat_acc_d    = sat_acc_q | spk_ovf;
        rate_out_d   = rate_out_q;
        rate_sat_d   = rate_sat_q;
        rate_valid_d = 1'b0;

        // An event in the final window cycle is folded into the closing
        // window's result; the new window starts from zero.
        if (win_end) begin
            rate_out_d   = spk_next;
            rate_sat_d   = sat_acc_q | spk_ovf;
            rate_valid_d = 1'b1;
            spk_d        = '0;
            sat_acc_d    = 1'b0;
        end
    end

    always_comb begin
        isi_inc     = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_W));
        isi_state_d = isi_state_q;
        isi_cnt_d   = isi_cnt_q;
        isi_out_d   = isi_out_q;
        isi_sat_d   = isi_sat_q;
        isi_valid_d = 1'b0;

        case (isi_state_q)
            ISI_IDLE: begin
                if (spike_event) begin
                    isi_state_d = ISI_ARMED;
                    isi_cnt_d   = '0;
                end
            end
            ISI_ARMED: begin
                // The event cycle itself counts toward the interval, so
                // spikes k enabled cycles apart report k.
                if (spike_event) begin
                    isi_out_d   = isi_inc;
                    isi_sat_d   = (isi_inc == '1);
                    isi_valid_d = 1'b1;
                    isi_cnt_d   = '0;
                end else if (enable) begin
                    isi_cnt_d   = isi_inc;
                end
            end
            default: isi_state_d = ISI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q        <= '0;
            spk_q        <= '0;
            sat_acc_q    <= 1'b0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            rate_sat_q   <= 1'b0;
            isi_state_q  <= ISI_IDLE;
            isi_cnt_q    <= '0;
            isi_out_q    <= '0;
            isi_valid_q  <= 1'b0;
            isi_sat_q    <= 1'b0;
        end else begin
            win_q        <= win_d;
            spk_q        <= spk_d;
            sat_acc_q    <= sat_acc_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            rate_sat_q   <= rate_sat_d;
            isi_state_q  <= isi_state_d;
            isi_cnt_q    <= isi_cnt_d;
            isi_out_q    <= isi_out_d;
            isi_valid_q  <= isi_valid_d;
            isi_sat_q    <= isi_sat_d;
        end
    end

    assign rate_out   = rate_out_q;
    assign rate_valid = rate_valid_q;
    assign rate_sat   = rate_sat_q;
    assign isi_out    = isi_out_q;
    assign isi_valid  = isi_valid_q;
    assign isi_sat    = isi_sat_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with a 16-cycle window, 3-bit rate
// count and 4-bit interval.
module tb_spike_rate_decoder;

    localparam int unsigned WL = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          spike_in = 1'b0;
    logic [CW-1:0] rate_out;
    logic          rate_valid;
    logic          rate_sat;
    logic [IW-1:0] isi_out;
    logic          isi_valid;
    logic          isi_sat;

    int passed = 0;
    int total  = 0;

    spike_rate_decoder #(
        .WINDOW_LOG2 (WL),
        .COUNT_W     (CW),
        .ISI_W       (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_sat   (rate_sat),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid),
        .isi_sat    (isi_sat)
    );

    always #5 clk = ~clk;

    // One clock: apply inputs, take the edge, sample 1 time unit later.
    task automatic tick(input logic en, input logic sp);
        enable   = en;
        spike_in = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({rate_out, rate_valid, rate_sat, isi_out, isi_valid, isi_sat} !== '0)
            $display("FAIL reset_outputs: got rate_out=%0d rv=%0b rs=%0b isi_out=%0d iv=%0b is=%0b, expected all 0",
                     rate_out, rate_valid, rate_sat, isi_out, isi_valid, isi_sat);
        else passed++;
    endtask

    task automatic test_idle_window();
        int rv = 0;
        int iv = 0;
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            tick(1'b1, 1'b0);
            rv += int'(rate_valid);
            iv += int'(isi_valid);
        end
        total++;
        if (rv !== 0) $display("FAIL idle_early_rv: got %0d pulses, expected 0", rv);
        else passed++;
        tick(1'b1, 1'b0);
        iv += int'(isi_valid);
        total++;
        if (rate_valid !== 1'b1) $display("FAIL idle_rv: got %0b expected 1", rate_valid);
        else passed++;
        total++;
        if (rate_out !== 3'd0 || rate_sat !== 1'b0)
            $display("FAIL idle_rate: got out=%0d sat=%0b expected 0/0", rate_out, rate_sat);
        else passed++;
        tick(1'b1, 1'b0);
        iv += int'(isi_valid);
        total++;
        if (rate_valid !== 1'b0) $display("FAIL idle_rv_pulse: got %0b expected 0", rate_valid);
        else passed++;
        total++;
        if (iv !== 0) $display("FAIL idle_iv: got %0d pulses, expected 0", iv);
        else passed++;
    endtask

    task automatic test_periodic();
        int iv = 0;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, (i % 4) == 1);
            iv += int'(isi_valid);
            if (i == 1) begin
                total++;
                if (isi_valid !== 1'b0) $display("FAIL periodic_first_iv: got %0b expected 0", isi_valid);
                else passed++;
            end
            if (i == 5) begin
                total++;
                if (isi_valid !== 1'b1 || isi_out !== 4'd4 || isi_sat !== 1'b0)
                    $display("FAIL periodic_isi: got iv=%0b out=%0d sat=%0b expected 1/4/0",
                             isi_valid, isi_out, isi_sat);
                else passed++;
            end
            if (i == 6) begin
                total++;
                if (isi_valid !== 1'b0 || isi_out !== 4'd4)
                    $display("FAIL periodic_isi_hold: got iv=%0b out=%0d expected 0/4", isi_valid, isi_out);
                else passed++;
            end
        end
        total++;
        if (rate_valid !== 1'b1 || rate_out !== 3'd4 || rate_sat !== 1'b0)
            $display("FAIL periodic_rate: got rv=%0b out=%0d sat=%0b expected 1/4/0",
                     rate_valid, rate_out, rate_sat);
        else passed++;
        total++;
        if (iv !== 3) $display("FAIL periodic_iv_count: got %0d expected 3", iv);
        else passed++;
    endtask

    task automatic test_held_and_sat();
        do_reset();
        for (int i = 1; i <= 16; i++) tick(1'b1, i <= 10);
        total++;
        if (rate_valid !== 1'b1 || rate_out !== 3'd1 || rate_sat !== 1'b0)
            $display("FAIL held_rate: got rv=%0b out=%0d sat=%0b expected 1/1/0",
                     rate_valid, rate_out, rate_sat);
        else passed++;
        for (int i = 1; i <= 16; i++) tick(1'b1, (i % 2) == 1);
        total++;
        if (rate_valid !== 1'b1 || rate_out !== 3'd7 || rate_sat !== 1'b1)
            $display("FAIL toggle_rate: got rv=%0b out=%0d sat=%0b expected 1/7/1",
                     rate_valid, rate_out, rate_sat);
        else passed++;
        tick(1'b1, 1'b0);
        total++;
        if (rate_valid !== 1'b0 || rate_sat !== 1'b1 || rate_out !== 3'd7)
            $display("FAIL rate_hold: got rv=%0b out=%0d sat=%0b expected 0/7/1",
                     rate_valid, rate_out, rate_sat);
        else passed++;
    endtask

    task automatic test_isi_sat();
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            tick(1'b1, i == 1 || i == 21 || i == 24);
            if (i == 21) begin
                total++;
                if (isi_valid !== 1'b1 || isi_out !== 4'd15 || isi_sat !== 1'b1)
                    $display("FAIL isi_sat_long: got iv=%0b out=%0d sat=%0b expected 1/15/1",
                             isi_valid, isi_out, isi_sat);
                else passed++;
            end
            if (i == 24) begin
                total++;
                if (isi_valid !== 1'b1 || isi_out !== 4'd3 || isi_sat !== 1'b0)
                    $display("FAIL isi_short: got iv=%0b out=%0d sat=%0b expected 1/3/0",
                             isi_valid, isi_out, isi_sat);
                else passed++;
            end
        end
    endtask

    task automatic test_last_cycle_and_enable();
        int rv = 0;
        int iv = 0;
        do_reset();
        for (int i = 1; i <= 16; i++) tick(1'b1, i == 16);
        total++;
        if (rate_valid !== 1'b1 || rate_out !== 3'd1)
            $display("FAIL last_cycle_rate: got rv=%0b out=%0d expected 1/1", rate_valid, rate_out);
        else passed++;
        // ticks 17..20 enabled idle, 21..25 disabled with spike high,
        // 26 re-enabled still high, 27 low, 28 spike, then idle to 37.
        for (int t = 17; t <= 36; t++) begin
            if (t <= 20)      tick(1'b1, 1'b0);
            else if (t <= 25) tick(1'b0, 1'b1);
            else              tick(1'b1, t == 26 || t == 28);
            rv += int'(rate_valid);
            if (t != 28) iv += int'(isi_valid);
            if (t == 28) begin
                total++;
                if (isi_valid !== 1'b1 || isi_out !== 4'd7)
                    $display("FAIL freeze_isi: got iv=%0b out=%0d expected 1/7", isi_valid, isi_out);
                else passed++;
            end
        end
        total++;
        if (rv !== 0) $display("FAIL freeze_early_rv: got %0d pulses expected 0", rv);
        else passed++;
        total++;
        if (iv !== 0) $display("FAIL freeze_spurious_iv: got %0d pulses expected 0", iv);
        else passed++;
        tick(1'b1, 1'b0);
        total++;
        if (rate_valid !== 1'b1 || rate_out !== 3'd1 || rate_sat !== 1'b0)
            $display("FAIL freeze_rate: got rv=%0b out=%0d sat=%0b expected 1/1/0",
                     rate_valid, rate_out, rate_sat);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 16; i++) tick(1'b1, i == 12 || i == 16);
        total++;
        if (rate_valid !== 1'b1 || isi_valid !== 1'b1)
            $display("FAIL simul_valids: got rv=%0b iv=%0b expected 1/1", rate_valid, isi_valid);
        else passed++;
        total++;
        if (rate_out !== 3'd2 || isi_out !== 4'd4)
            $display("FAIL simul_values: got rate=%0d isi=%0d expected 2/4", rate_out, isi_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int rv = 0;
        do_reset();
        for (int i = 1; i <= 6; i++) tick(1'b1, i == 1 || i == 3 || i == 5);
        total++;
        if (isi_out !== 4'd2) $display("FAIL pre_reset_isi: got %0d expected 2", isi_out);
        else passed++;
        reset = 1'b1;
        tick(1'b1, 1'b1);
        reset = 1'b0;
        total++;
        if ({rate_out, rate_valid, rate_sat, isi_out, isi_valid, isi_sat} !== '0)
            $display("FAIL mid_reset_outputs: got rate_out=%0d rv=%0b isi_out=%0d iv=%0b, expected all 0",
                     rate_out, rate_valid, isi_out, isi_valid);
        else passed++;
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, i == 2 || i == 10);
            if (i < 16) rv += int'(rate_valid);
            if (i == 2) begin
                total++;
                if (isi_valid !== 1'b0) $display("FAIL post_reset_first_iv: got %0b expected 0", isi_valid);
                else passed++;
            end
            if (i == 10) begin
                total++;
                if (isi_valid !== 1'b1 || isi_out !== 4'd8)
                    $display("FAIL post_reset_isi: got iv=%0b out=%0d expected 1/8", isi_valid, isi_out);
                else passed++;
            end
        end
        total++;
        if (rv !== 0) $display("FAIL post_reset_early_rv: got %0d pulses expected 0", rv);
        else passed++;
        total++;
        if (rate_valid !== 1'b1 || rate_out !== 3'd2 || rate_sat !== 1'b0)
            $display("FAIL post_reset_rate: got rv=%0b out=%0d sat=%0b expected 1/2/0",
                     rate_valid, rate_out, rate_sat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_idle_window();
        test_periodic();
        test_held_and_sat();
        test_isi_sat();
        test_last_cycle_and_enable();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
